// File: rtl/sprite_motion_ctrl.sv
// sprite_motion_ctrl: keyboard-driven sprite mover, advanced once per video frame.
// Decodes arrow-style keycodes into a per-axis direction. Speed ramps up while the
// same direction is held. Position saturates at the screen limits. Outputs also
// report facing direction, limit contact and a walk-cycle animation index.
module sprite_motion_ctrl #(
    parameter int W            = 10,
    parameter int NUM_KEYS     = 2,
    parameter int X_MIN        = 0,
    parameter int X_MAX        = 639,
    parameter int Y_MIN        = 0,
    parameter int Y_MAX        = 479,
    parameter int X_CENTER     = 320,
    parameter int Y_CENTER     = 240,
    parameter int SIZE         = 4,
    parameter int STEP_MAX     = 4,
    parameter int ACCEL_FRAMES = 8,
    parameter int ANIM_DIV     = 8
) (
    input  logic                  frame_clk,
    input  logic                  Reset,
    input  logic [8*NUM_KEYS-1:0] keycodes,
    output logic [W-1:0]          SpriteX,
    output logic [W-1:0]          SpriteY,
    output logic [W-1:0]          SpriteS,
    output logic                  moving,
    output logic [3:0]            at_edge,
    output logic [1:0]            facing,
    output logic [1:0]            anim_frame
);

    localparam int SW = $clog2(STEP_MAX + 1);
    localparam int HW = $clog2(ACCEL_FRAMES + 1);
    localparam int AW = $clog2(ANIM_DIV + 1);

    localparam logic [SW-1:0] SPD_ONE   = SW'(1);
    localparam logic [SW-1:0] SPD_MAX   = SW'(STEP_MAX);
    localparam logic [HW-1:0] HOLD_LAST = HW'(ACCEL_FRAMES - 1);
    localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_DIV - 1);

    // Centre limits are kept one bit wider than the position so that the
    // subtract/add comparisons below never wrap.
    localparam logic [W:0] X_LO = (W+1)'(X_MIN + SIZE);
    localparam logic [W:0] X_HI = (W+1)'(X_MAX - SIZE);
    localparam logic [W:0] Y_LO = (W+1)'(Y_MIN + SIZE);
    localparam logic [W:0] Y_HI = (W+1)'(Y_MAX - SIZE);

    // Per-axis direction encoding: 01 = +1, 11 = -1, 00 = still.
    localparam logic [1:0] D_POS = 2'b01;
    localparam logic [1:0] D_NEG = 2'b11;

    // Elaboration-time guard on parameters that would break the ramp or the range logic.
    if (STEP_MAX < 1 || ACCEL_FRAMES < 1 || ANIM_DIV < 1) begin : g_bad_rate
        $error("sprite_motion_ctrl: STEP_MAX, ACCEL_FRAMES and ANIM_DIV must be >= 1");
    end
    if (X_CENTER < X_MIN + SIZE || X_CENTER > X_MAX - SIZE ||
        Y_CENTER < Y_MIN + SIZE || Y_CENTER > Y_MAX - SIZE) begin : g_bad_center
        $error("sprite_motion_ctrl: reset centre lies outside the valid range");
    end

    logic          key_l, key_r, key_u, key_d;
    logic [1:0]    dx, dy;
    logic [3:0]    dir, prev_dir;
    logic [SW-1:0] speed, spd_eff;
    logic [HW-1:0] hold_cnt;
    logic [AW-1:0] anim_cnt;
    logic [W:0]    spd_w, x_ext, y_ext, x_next, y_next;
    logic [W-1:0]  nx, ny;
    logic          move_now;

    assign SpriteS = W'(SIZE);

    // Key decode: any slot holding a direction code sets that direction; duplicates simply OR.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        key_l = 1'b0;
        key_r = 1'b0;
        key_u = 1'b0;
        key_d = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            case (keycodes[8*k +: 8])
                8'h04:   key_l = 1'b1;
                8'h07:   key_r = 1'b1;
                8'h16:   key_d = 1'b1;
                8'h1A:   key_u = 1'b1;
                default: ;
            endcase
        end
    end

    // Opposite keys on one axis cancel out.
    assign dx      = (key_r && !key_l) ? D_POS : (key_l && !key_r) ? D_NEG : 2'b00;
    assign dy      = (key_d && !key_u) ? D_POS : (key_u && !key_d) ? D_NEG : 2'b00;
    assign dir     = {dx, dy};
    assign spd_eff = (dir != prev_dir) ? SPD_ONE : speed;

    assign spd_w = (W+1)'(spd_eff);
    assign x_ext = {1'b0, SpriteX};
    assign y_ext = {1'b0, SpriteY};

    // Next position: step by this frame's effective speed, saturating exactly at each limit.
    always_comb begin
        x_next = x_ext;
        y_next = y_ext;
        if (dx == D_POS)
            x_next = (x_ext + spd_w >= X_HI) ? X_HI : x_ext + spd_w;
        else if (dx == D_NEG)
            x_next = (x_ext >= X_LO + spd_w) ? x_ext - spd_w : X_LO;
        if (dy == D_POS)
            y_next = (y_ext + spd_w >= Y_HI) ? Y_HI : y_ext + spd_w;
        else if (dy == D_NEG)
            y_next = (y_ext >= Y_LO + spd_w) ? y_ext - spd_w : Y_LO;
    end

    assign nx       = x_next[W-1:0];
    assign ny       = y_next[W-1:0];
    assign move_now = (nx != SpriteX) || (ny != SpriteY);

    assign at_edge = {y_ext == Y_LO, y_ext == Y_HI, x_ext == X_HI, x_ext == X_LO};

    // Position, speed ramp, facing and movement flag, all advanced once per frame.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            SpriteX  <= W'(X_CENTER);
            SpriteY  <= W'(Y_CENTER);
            speed    <= SPD_ONE;
            hold_cnt <= '0;
            prev_dir <= '0;
            moving   <= 1'b0;
            facing   <= 2'b00;
        end else begin
            // NOTE: registered state uses non-blocking assignments so every update samples pre-edge values.
            SpriteX  <= nx;
            SpriteY  <= ny;
            moving   <= move_now;
            prev_dir <= dir;
            if (dir == 4'b0000 || dir != prev_dir) begin
                speed    <= SPD_ONE;
                hold_cnt <= '0;
            end else if (hold_cnt == HOLD_LAST) begin
                hold_cnt <= '0;
                speed    <= (speed < SPD_MAX) ? speed + SPD_ONE : SPD_MAX;
            end else begin
                hold_cnt <= hold_cnt + HW'(1);
            end
            if (dx != 2'b00)
                facing <= (dx == D_POS) ? 2'b11 : 2'b10;
            else if (dy != 2'b00)
                facing <= (dy == D_POS) ? 2'b00 : 2'b01;
        end
    end

    // Walk cycle: advances every ANIM_DIV moving frames, snaps back to 0 when the sprite stops.
    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            anim_cnt   <= '0;
            anim_frame <= 2'b00;
        end else if (!move_now) begin
            anim_cnt   <= '0;
            anim_frame <= 2'b00;
        end else if (anim_cnt == ANIM_LAST) begin
            anim_cnt   <= '0;
            anim_frame <= anim_frame + 2'b01;
        end else begin
            anim_cnt <= anim_cnt + AW'(1);
        end
    end

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb_sprite_motion_ctrl: directed self-checking bench for sprite_motion_ctrl.
// Built with ACCEL_FRAMES=4 and STEP_MAX=3 so the speed ramp is short.
module tb_sprite_motion_ctrl;

    logic        frame_clk;
    logic        Reset;
    logic [15:0] keycodes;
    logic [9:0]  SpriteX, SpriteY, SpriteS;
    logic        moving;
    logic [3:0]  at_edge;
    logic [1:0]  facing, anim_frame;

    int n_checks = 0;
    int n_errors = 0;

    // Hand-derived per-frame steps for a held key from rest (ACCEL_FRAMES=4, STEP_MAX=3).
    int ramp_steps[10] = '{1, 1, 1, 1, 1, 2, 2, 2, 2, 3};

    sprite_motion_ctrl #(
        .STEP_MAX     (3),
        .ACCEL_FRAMES (4)
    ) dut (
        .frame_clk  (frame_clk),
        .Reset      (Reset),
        .keycodes   (keycodes),
        .SpriteX    (SpriteX),
        .SpriteY    (SpriteY),
        .SpriteS    (SpriteS),
        .moving     (moving),
        .at_edge    (at_edge),
        .facing     (facing),
        .anim_frame (anim_frame)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one frame and settle just after the edge.
    task automatic frame();
        @(posedge frame_clk);
        #1;
    endtask

    // Pulse Reset between edges, then check the reset state.
    task automatic do_reset();
        @(negedge frame_clk);
        Reset = 1'b1;
        #1;
        check("rst x", SpriteX, 320);
        check("rst y", SpriteY, 240);
        check("rst moving", moving, 0);
        check("rst facing", facing, 0);
        check("rst anim", anim_frame, 0);
        #1;
        Reset = 1'b0;
    endtask

    // Hold right for ten frames from rest, checking every step of the ramp.
    task automatic ramp10();
        int ex;
        ex = 320;
        keycodes = 16'h0007;
        for (int i = 0; i < 10; i++) begin
            frame();
            ex += ramp_steps[i];
            check($sformatf("ramp x f%0d", i), SpriteX, ex);
            check($sformatf("ramp moving f%0d", i), moving, 1);
        end
    endtask

    initial begin
        keycodes = 16'h0000;
        Reset    = 1'b0;
        #1;
        Reset = 1'b1;
        #1;
        check("init x", SpriteX, 320);
        check("init y", SpriteY, 240);
        check("init size", SpriteS, 4);
        check("init moving", moving, 0);
        check("init facing", facing, 0);
        check("init anim", anim_frame, 0);
        check("init at_edge", at_edge, 0);
        @(negedge frame_clk);
        Reset = 1'b0;

        // Ramp: 1,1,1,1,1,2,2,2,2,3 -> 336.
        ramp10();
        check("ramp facing", facing, 3);
        check("ramp anim", anim_frame, 1);
        check("ramp y", SpriteY, 240);

        // Opposite keys cancel: no motion, facing kept, animation cleared.
        keycodes = 16'h0704;
        frame();
        check("opp x", SpriteX, 336);
        check("opp moving", moving, 0);
        check("opp facing", facing, 3);
        check("opp anim", anim_frame, 0);
        // Duplicate right code counts once; restart at speed 1.
        keycodes = 16'h0707;
        frame();
        check("dup x", SpriteX, 337);
        check("dup moving", moving, 1);

        // Direction change after ramping to speed 3: first down step is 1, X frozen.
        do_reset();
        ramp10();
        keycodes = 16'h0016;
        frame();
        check("turn x", SpriteX, 336);
        check("turn y", SpriteY, 241);
        check("turn facing", facing, 0);
        frame();
        check("turn y2", SpriteY, 242);

        // Reset between edges while moving at speed 3.
        do_reset();
        ramp10();
        @(posedge frame_clk);
        #3;
        Reset = 1'b1;
        #1;
        check("midrst x", SpriteX, 320);
        check("midrst y", SpriteY, 240);
        check("midrst anim", anim_frame, 0);
        check("midrst moving", moving, 0);
        #1;
        Reset = 1'b0;
        frame();
        check("postrst x", SpriteX, 321);

        // Diagonal left+up for three frames.
        do_reset();
        keycodes = 16'h1A04;
        repeat (3) frame();
        check("diag x", SpriteX, 317);
        check("diag y", SpriteY, 237);
        check("diag facing", facing, 2);

        // Clamp at the left limit (centre minimum = 4).
        do_reset();
        keycodes = 16'h0004;
        repeat (109) frame();
        check("clamp pre x", SpriteX, 7);
        check("clamp pre edge", at_edge, 0);
        keycodes = 16'h0000;
        frame();
        check("clamp idle x", SpriteX, 7);
        check("clamp idle moving", moving, 0);
        keycodes = 16'h0004;
        frame();
        check("clamp x6", SpriteX, 6);
        frame();
        check("clamp x5", SpriteX, 5);
        frame();
        check("clamp x4", SpriteX, 4);
        check("clamp x4 moving", moving, 1);
        check("clamp x4 edge", at_edge, 4'b0001);
        frame();
        check("clamp hold x", SpriteX, 4);
        check("clamp hold moving", moving, 0);
        check("clamp hold edge", at_edge, 4'b0001);
        check("clamp hold anim", anim_frame, 0);
        check("clamp facing", facing, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sprite_motion_ctrl.md
SPRITE_MOTION_CTRL -- requirements
Module: sprite_motion_ctrl

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- W, 10, coordinate width in bits.
- NUM_KEYS, 2, number of simultaneous 8-bit keycode slots.
- X_MIN, 0, leftmost screen coordinate.
- X_MAX, 639, rightmost screen coordinate.
- Y_MIN, 0, topmost screen coordinate.
- Y_MAX, 479, bottommost screen coordinate.
- X_CENTER, 320, reset X position.
- Y_CENTER, 240, reset Y position.
- SIZE, 4, sprite half-size.
- STEP_MAX, 4, maximum speed in pixels per frame.
- ACCEL_FRAMES, 8, frames per speed increment.
- ANIM_DIV, 8, frames per animation step.

REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- frame_clk, in, 1, the single clock (one edge per video frame).
- Reset, in, 1, asynchronous, active-high.
- keycodes, in, 8*NUM_KEYS, slot k at bits [8k+7:8k].
- SpriteX, out, W, centre X.
- SpriteY, out, W, centre Y.
- SpriteS, out, W, constant SIZE.
- moving, out, 1, position changed on the last edge.
- at_edge, out, 4, {up, down, right, left} limit flags.
- facing, out, 2, 00 down, 01 up, 10 left, 11 right.
- anim_frame, out, 2, walk-cycle index.

Function
REQ-003 Key decoding SHALL work as follows:
- 8'h04 = left, 8'h07 = right, 8'h16 = down, 8'h1A = up, detected in any slot.
- Other codes are ignored.
- A duplicate code in two slots counts once.

REQ-004 Per-axis direction SHALL be derived as follows:
- dx = +1 if right only, -1 if left only, 0 if neither or both.
- dy is derived the same way (down = +1, up = -1).
- dir = {dx, dy}.

REQ-005 Valid centre range SHALL be [X_MIN+SIZE, X_MAX-SIZE] and [Y_MIN+SIZE, Y_MAX-SIZE].
- Arithmetic is done at W+1 bits so no underflow or overflow wraps.

REQ-006 Effective speed spd_eff SHALL be 1 when dir differs from the registered prev_dir, else the registered speed.

REQ-007 On each frame_clk edge, each axis with nonzero d SHALL move by spd_eff and saturate exactly at its range limit.
- The same-edge spd_eff is used, not a one-frame-stale motion value.
- Position never leaves the range.

REQ-008 Speed ramp SHALL follow these rules:
- dir = 0: speed <= 1, hold_cnt <= 0.
- dir != prev_dir: speed <= 1, hold_cnt <= 0.
- Otherwise, if hold_cnt == ACCEL_FRAMES-1: hold_cnt <= 0, speed <= min(speed+1, STEP_MAX).
- Otherwise hold_cnt increments.
- prev_dir <= dir every edge.

REQ-009 moving SHALL be registered: 1 if SpriteX or SpriteY changed on this edge, else 0.
- Held key against a limit: moving = 0.

REQ-010 at_edge bits SHALL be combinational equality of registered position to the respective limit.

REQ-011 facing SHALL update on each edge with nonzero dir: horizontal direction if dx != 0, else vertical; otherwise it holds.

REQ-012 anim_frame SHALL follow these rules:
- An internal counter increments on each edge with moving = 1.
- On reaching ANIM_DIV-1 the counter clears and anim_frame increments, wrapping 3 to 0.
- Any edge with moving = 0 clears both the counter and anim_frame.

REQ-013 Parameter range SHALL be STEP_MAX >= 1, ACCEL_FRAMES >= 1, ANIM_DIV >= 1, and X_CENTER/Y_CENTER inside the valid range.

Reset
REQ-014 Reset SHALL act asynchronously, overriding any motion in progress, and set:
- SpriteX = X_CENTER, SpriteY = Y_CENTER.
- speed = 1, hold_cnt = 0, prev_dir = 0.
- moving = 0, facing = 00, anim_frame = 0 and its counter = 0.
- SpriteS always equals SIZE.

REQ-015 The first edge after Reset deasserts SHALL be treated as a normal frame.

Verification
REQ-016 Ramp (ACCEL_FRAMES=4, STEP_MAX=3), from reset hold 8'h07 for 10 frames -> steps 1,1,1,1,1,2,2,2,2,3; SpriteX = 336, facing = 11, moving = 1.

REQ-017 Clamp: from SpriteX=6, hold 8'h04 -> SpriteX 5 then 4, then stays 4; at_edge = 0001, moving = 0 after the saturating frame.

REQ-018 Opposite keys: slots {8'h04, 8'h07} -> SpriteX unchanged, speed = 1, moving = 0, facing unchanged.

REQ-019 Diagonal: {8'h04, 8'h1A} from reset for 3 frames -> (317, 237), facing = 10.

REQ-020 Direction change: after ramp to speed 3 rightward, switch to 8'h16 -> first down step = 1, no X change.

REQ-021 Reset mid-motion: assert Reset between edges while moving at speed 3 -> outputs return immediately to (320, 240), anim_frame = 0; next held-key frame moves by 1.
